// File: rtl/vt52_pkg.sv
// Shared VT52 text-buffer geometry, arbiter state encoding and circular-address helpers.
package vt52_pkg;

  localparam int ROWS      = 24;
  localparam int COLS      = 80;
  localparam int ADDR_BITS = 11;
  localparam int BUF_SIZE  = ROWS * COLS;

  localparam logic [ADDR_BITS-1:0] BUF_SIZE_A = ADDR_BITS'(BUF_SIZE);
  localparam logic [ADDR_BITS-1:0] BUF_LAST   = ADDR_BITS'(BUF_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // A single subtraction is enough: the largest address (2047) is below 2*BUF_SIZE.
  function automatic logic [ADDR_BITS-1:0] buf_reduce(input logic [ADDR_BITS-1:0] a);
    return (a >= BUF_SIZE_A) ? a - BUF_SIZE_A : a;
  endfunction

  function automatic logic [ADDR_BITS-1:0] buf_clamp(input logic [ADDR_BITS-1:0] n);
    return (n > BUF_SIZE_A) ? BUF_SIZE_A : n;
  endfunction

  function automatic logic [ADDR_BITS-1:0] buf_wrap_inc(input logic [ADDR_BITS-1:0] a);
    return (a == BUF_LAST) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loadable circular address counter (wraps at BUF_SIZE-1) paired with a remaining-cells
// down counter; empty flags that every cell of the range has been issued.
module wrap_counter
  import vt52_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [ADDR_BITS-1:0] load_cur,
  input  logic [ADDR_BITS-1:0] load_rem,
  output logic [ADDR_BITS-1:0] cur,
  output logic                 empty
);

  logic [ADDR_BITS-1:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= '0;
      remaining <= '0;
    end else if (load) begin
      cur       <= load_cur;
      remaining <= load_rem;
    end else if (step && (remaining != '0)) begin
      cur       <= buf_wrap_inc(cur);
      remaining <= remaining - 1'b1;
    end
  end

  assign empty = (remaining == '0);

endmodule

// File: rtl/char_write_arbiter.sv
// Owns the char_buffer write port: arbitrates single command_handler writes against the
// circular fill engine used for erase operations. All buf_* outputs are registered.
//
// state | meaning
// IDLE  | accepts cmd writes and fill requests; a lone fill issues its first cell at once
// FILL  | one cell per clock from the counter; one trailing cycle once the range is empty
// DONE  | fill_done pulse, no writes, back to IDLE
module char_write_arbiter
  import vt52_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           cmd_char,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           fill_char,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [ADDR_BITS-1:0] fill_len,
  input  logic                 fill_start,
  output logic                 fill_ready,
  output logic                 fill_done,
  output logic [7:0]           buf_char,
  output logic [ADDR_BITS-1:0] buf_addr,
  output logic                 buf_wen
);

  arb_state_e           state, state_nxt;
  logic                 cmd_acc, fill_acc;
  logic [ADDR_BITS-1:0] fill_base, fill_cnt;
  logic                 issue_wen;
  logic [ADDR_BITS-1:0] issue_addr;
  logic [7:0]           issue_char;
  logic                 cnt_load, cnt_step, cnt_empty;
  logic [ADDR_BITS-1:0] load_cur, load_rem, cur;
  logic                 fill_char_load;
  logic [7:0]           fill_char_q;

  assign cmd_ready  = (state == IDLE);
  assign fill_ready = (state == IDLE);
  assign fill_done  = (state == DONE);

  assign cmd_acc   = cmd_valid && cmd_ready;
  assign fill_acc  = fill_start && fill_ready;
  assign fill_base = buf_reduce(fill_addr);
  assign fill_cnt  = buf_clamp(fill_len);

  wrap_counter u_wrap_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .step     (cnt_step),
    .load_cur (load_cur),
    .load_rem (load_rem),
    .cur      (cur),
    .empty    (cnt_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    issue_wen      = 1'b0;
    issue_addr     = '0;
    issue_char     = '0;
    cnt_load       = 1'b0;
    cnt_step       = 1'b0;
    load_cur       = fill_base;
    load_rem       = fill_cnt;
    fill_char_load = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_acc) begin
          issue_wen  = 1'b1;
          issue_addr = buf_reduce(cmd_addr);
          issue_char = cmd_char;
        end
        if (fill_acc) begin
          fill_char_load = 1'b1;
          cnt_load       = 1'b1;
          state_nxt      = FILL;
          // Without a competing cmd the first cell goes out now so a fill of L cells
          // occupies exactly the L cycles after acceptance.
          if (!cmd_acc) begin
            if (fill_cnt == '0) begin
              state_nxt = DONE;
            end else begin
              issue_wen  = 1'b1;
              issue_addr = fill_base;
              issue_char = fill_char;
              load_cur   = buf_wrap_inc(fill_base);
              load_rem   = fill_cnt - 1'b1;
            end
          end
        end
      end
      FILL: begin
        if (cnt_empty) begin
          state_nxt = DONE;
        end else begin
          issue_wen  = 1'b1;
          issue_addr = cur;
          issue_char = fill_char_q;
          cnt_step   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_wen     <= 1'b0;
      buf_addr    <= '0;
      buf_char    <= '0;
      fill_char_q <= '0;
    end else begin
      buf_wen <= issue_wen;
      if (issue_wen) begin
        buf_addr <= issue_addr;
        buf_char <= issue_char;
      end
      if (fill_char_load) fill_char_q <= fill_char;
    end
  end

endmodule

// File: tb/tb_char_write_arbiter.sv
// Randomized and directed bench for char_write_arbiter against a cycle-scheduled
// transaction model of the write arbitration and circular fill rules.
module tb_char_write_arbiter;

  localparam int BUF = 1920;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cmd_char;
  logic [10:0] cmd_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  fill_char;
  logic [10:0] fill_addr;
  logic [10:0] fill_len;
  logic        fill_start;
  logic        fill_ready;
  logic        fill_done;
  logic [7:0]  buf_char;
  logic [10:0] buf_addr;
  logic        buf_wen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_from = 0;
  bit cmd_taken = 0;

  int exp_addr [int];
  int exp_char [int];
  bit exp_done [int];
  logic [7:0] model_mem [0:BUF-1];
  logic [7:0] dut_mem [0:2047];

  char_write_arbiter dut (
    .clk        (clk),
    .reset      (rst_n),
    .cmd_char   (cmd_char),
    .cmd_addr   (cmd_addr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .fill_char  (fill_char),
    .fill_addr  (fill_addr),
    .fill_len   (fill_len),
    .fill_start (fill_start),
    .fill_ready (fill_ready),
    .fill_done  (fill_done),
    .buf_char   (buf_char),
    .buf_addr   (buf_addr),
    .buf_wen    (buf_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Schedules the effect of whatever the bench drives in the current cycle.
  task automatic model_accept();
    int a, len, start;
    cmd_taken = 0;
    if (!rst_n || cyc < idle_from) return;
    if (cmd_valid) begin
      a = int'(cmd_addr) % BUF;
      exp_addr[cyc+1] = a;
      exp_char[cyc+1] = int'(cmd_char);
      model_mem[a] = cmd_char;
      cmd_taken = 1;
    end
    if (fill_start) begin
      len   = (int'(fill_len) > BUF) ? BUF : int'(fill_len);
      start = cyc + 1 + (cmd_valid ? 1 : 0);
      for (int k = 0; k < len; k++) begin
        a = (int'(fill_addr) + k) % BUF;
        exp_addr[start+k] = a;
        exp_char[start+k] = int'(fill_char);
        model_mem[a] = fill_char;
      end
      exp_done[start+len] = 1;
      idle_from = start + len + 1;
    end
  endtask

  task automatic check_cycle();
    bit ew, ed, idle;
    ew   = exp_addr.exists(cyc);
    ed   = exp_done.exists(cyc);
    idle = (cyc >= idle_from);
    chk("buf_wen", 32'(buf_wen), 32'(ew));
    if (ew) begin
      chk("buf_addr", 32'(buf_addr), exp_addr[cyc]);
      chk("buf_char", 32'(buf_char), exp_char[cyc]);
      exp_addr.delete(cyc);
      exp_char.delete(cyc);
    end
    chk("fill_done", 32'(fill_done), 32'(ed));
    if (ed) exp_done.delete(cyc);
    chk("cmd_ready", 32'(cmd_ready), 32'(idle));
    chk("fill_ready", 32'(fill_ready), 32'(idle));
    if (buf_wen) dut_mem[buf_addr] = buf_char;
  endtask

  task automatic advance();
    model_accept();
    @(negedge clk);
    check_cycle();
    if (cmd_taken) cmd_valid = 0;
  endtask

  task automatic run_until_idle();
    int guard = 0;
    while (cyc < idle_from + 1 && guard < 5000) begin
      advance();
      guard++;
    end
    chk("idle_reached", 32'(cyc >= idle_from + 1), 1);
  endtask

  task automatic start_fill(input int addr, input int len, input int ch);
    fill_addr  = 11'(addr);
    fill_len   = 11'(len);
    fill_char  = 8'(ch);
    fill_start = 1;
  endtask

  task automatic set_cmd(input int addr, input int ch);
    cmd_addr  = 11'(addr);
    cmd_char  = 8'(ch);
    cmd_valid = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    cmd_char = 0; cmd_addr = 0; cmd_valid = 0;
    fill_char = 0; fill_addr = 0; fill_len = 0; fill_start = 0;
    for (int i = 0; i < BUF; i++) model_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) dut_mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_buf_wen", 32'(buf_wen), 0);
    chk("rst_buf_addr", 32'(buf_addr), 0);
    chk("rst_buf_char", 32'(buf_char), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_fill_ready", 32'(fill_ready), 1);
    rst_n = 1;
    idle_from = cyc;
    repeat (5) advance();

    set_cmd(5, 8'h41);
    repeat (3) advance();

    start_fill(1915, 10, 8'h20);
    advance();
    fill_start = 0;
    run_until_idle();

    start_fill(1920, 2000, 8'h2E);
    advance();
    fill_start = 0;
    run_until_idle();

    start_fill(7, 0, 8'h30);
    advance();
    fill_start = 0;
    run_until_idle();

    set_cmd(2047, 8'h42);
    repeat (2) advance();

    // Held cmd and a repeated fill_start while the engine is busy.
    start_fill(100, 8, 8'h2B);
    advance();
    start_fill(300, 3, 8'h3F);
    set_cmd(50, 8'h43);
    repeat (4) advance();
    fill_start = 0;
    run_until_idle();
    repeat (2) advance();

    set_cmd(10, 8'h55);
    start_fill(10, 1, 8'h66);
    advance();
    fill_start = 0;
    run_until_idle();
    advance();
    chk("cell10_final", 32'(dut_mem[10]), 32'h66);

    // Reset lands on the third write of a 100-cell fill.
    start_fill(500, 100, 8'h2D);
    advance();
    fill_start = 0;
    repeat (2) advance();
    rst_n = 0;
    #1;
    chk("midrst_buf_wen", 32'(buf_wen), 0);
    chk("midrst_fill_done", 32'(fill_done), 0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 1);
    exp_addr.delete();
    exp_char.delete();
    exp_done.delete();
    idle_from = 0;
    repeat (3) advance();
    rst_n = 1;
    idle_from = cyc;
    repeat (110) advance();
    start_fill(1900, 30, 8'h2A);
    advance();
    fill_start = 0;
    run_until_idle();

    for (int i = 0; i < 1500; i++) begin
      if (!cmd_valid && $urandom_range(0, 3) == 0)
        set_cmd(int'($urandom_range(0, 2047)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0)
        start_fill(int'($urandom_range(0, 2047)),
                   ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047))
                                                 : int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 255)));
      else
        fill_start = 0;
      advance();
    end
    fill_start = 0;
    run_until_idle();
    repeat (3) advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_write_arbiter.md
Name: char_write_arbiter

Overview:
- Owns the single write port of char_buffer, in the clk_usb domain.
- Arbitrates between two sources:
  - single-character writes from command_handler (valid/ready handshake);
  - a built-in fill engine that writes one character across a contiguous, circularly wrapped range. Used for erase-line, erase-screen and erase-to-end on scroll.
- Sits between command_handler and char_buffer.
- command_handler becomes a requester instead of driving char_buffer directly.

Parameters:
- ROWS, 24, text rows on screen
- COLS, 80, text columns on screen
- ADDR_BITS, 11, char_buffer address width
- BUF_SIZE, ROWS*COLS (1920), circular screen-buffer length; all addresses are taken modulo BUF_SIZE

Ports:
- clk  in  1  clock (clk_usb domain)
- reset  in  1  asynchronous, active-low reset
- cmd_char  in  8  character to write
- cmd_addr  in  ADDR_BITS  write address
- cmd_valid  in  1  single-write request
- cmd_ready  out  1  single write accepted when cmd_valid && cmd_ready
- fill_char  in  8  fill character
- fill_addr  in  ADDR_BITS  fill start address
- fill_len  in  ADDR_BITS  number of cells to fill
- fill_start  in  1  fill request; accepted when fill_start && fill_ready
- fill_ready  out  1  fill engine idle
- fill_done  out  1  one-cycle pulse when a fill completes
- buf_char  out  8  to char_buffer din
- buf_addr  out  ADDR_BITS  to char_buffer waddr
- buf_wen  out  1  to char_buffer wen

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; buf_wen=0, buf_addr=0, buf_char=0.
  - fill_done=0; cmd_ready=1, fill_ready=1.
  - Release is synchronous to clk.
  - Reset asserted mid-fill aborts the fill immediately: no further writes, no fill_done.
- Outputs:
  - buf_* are registered.
  - An accepted request appears on buf_* exactly one cycle after acceptance.
  - buf_wen is high for exactly one cycle per written cell.
- States: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready=1, fill_ready=1.
  - Accepted cmd: next cycle buf_wen=1, buf_addr=cmd_addr mod BUF_SIZE, buf_char=cmd_char.
  - Accepted fill:
    - latch fill_char;
    - cur = fill_addr mod BUF_SIZE;
    - remaining = min(fill_len, BUF_SIZE);
    - if remaining==0 go to DONE, else go to FILL.
  - Both accepted in the same cycle:
    - cmd write is issued first (cycle N+1);
    - first fill write is in cycle N+2;
    - the fill therefore overwrites the cmd cell if it lies inside the range.
- FILL:
  - cmd_ready=0, fill_ready=0.
  - Each cycle: write cur; cur = (cur==BUF_SIZE-1) ? 0 : cur+1; remaining -= 1.
  - When the last cell is issued, go to DONE.
  - Throughput is 1 cell/clk, so a fill of L cells occupies cycles N+1 .. N+L.
- DONE:
  - fill_done=1 for one cycle; buf_wen=0.
  - cmd_ready=0, fill_ready=0.
  - Next state IDLE.
- Modulo reduction:
  - an input ≥ BUF_SIZE is reduced by a single subtraction of BUF_SIZE, valid because 2047 < 2*1920;
  - so 1920 maps to 0 and 2047 maps to 127.
- Request handling:
  - fill_start while fill_ready=0 is ignored; not queued.
  - cmd_valid while cmd_ready=0 is held by the requester and must remain stable.
- Width rules: remaining is ADDR_BITS wide; clamping to BUF_SIZE prevents the counter from exceeding range.
- No combinational path from any input to buf_*.
- cmd_ready and fill_ready are decoded from state only.

Decomposition:
- Shared package (vt52_pkg) holds:
  - BUF_SIZE, derived from ROWS/COLS;
  - the arbiter state enum {IDLE, FILL, DONE};
  - a modulo-BUF_SIZE reduce function, reused by command_handler for scroll arithmetic.
- One natural sub-module: wrap_counter.
  - Loadable, with wrap at BUF_SIZE-1.
  - Outputs cur plus a remaining-count down counter with a last flag.
  - Also reusable by the scroll logic.

Test Plan:
- Reset then idle:
  - with reset low, all buf_* and fill_done are 0, cmd_ready=1, fill_ready=1;
  - after release with no requests, buf_wen stays 0.
- Single write:
  - cmd_valid with cmd_addr=5, cmd_char=0x41;
  - next cycle buf_wen=1, buf_addr=5, buf_char=0x41, for one cycle only.
- Fill with wrap:
  - fill_addr=1915, fill_len=10, fill_char=0x20;
  - expect 10 consecutive writes at 1915..1919, 0..4;
  - fill_done pulses the cycle after addr 4;
  - fill_ready returns the cycle after that.
- Clamp, zero and out-of-range:
  - fill_len=2000, fill_addr=1920: 1920 writes starting at 0;
  - fill_len=0: no writes, fill_done one cycle after acceptance;
  - cmd_addr=2047 writes to addr 127.
- Contention:
  - cmd_valid held during a fill: cmd_ready=0 throughout FILL and DONE;
  - the cmd write occurs 1 cycle after IDLE is re-entered;
  - fill_start during FILL is ignored (exactly one fill_done).
  - Same-cycle cmd (addr 10) and fill (addr 10, len 1): write cmd then fill; final cell holds fill_char.
- Reset mid-fill:
  - assert reset on the 3rd write of a 100-cell fill;
  - buf_wen drops asynchronously and no fill_done occurs;
  - after release the block is IDLE and accepts a new fill normally.
